// File: rtl/vga_embarcacao_if.sv
// Ship renderer bus: video timing and game state in, pixel colour and sunk flag out.
interface vga_embarcacao_if #(
    parameter int N_CELLS = 3
);
    logic                   areaAtiva;
    logic                   inicioQuadro;
    logic [9:0]             linha;
    logic [9:0]             coluna;
    logic [8*N_CELLS-1:0]   posicoesEmbarcacao;
    logic [N_CELLS-1:0]     acertos;
    logic                   visivel;
    logic                   rgb_r;
    logic                   rgb_g;
    logic                   rgb_b;
    logic                   afundada;

    modport master (
        output areaAtiva, inicioQuadro, linha, coluna,
        output posicoesEmbarcacao, acertos, visivel,
        input  rgb_r, rgb_g, rgb_b, afundada
    );

    modport slave (
        input  areaAtiva, inicioQuadro, linha, coluna,
        input  posicoesEmbarcacao, acertos, visivel,
        output rgb_r, rgb_g, rgb_b, afundada
    );
endinterface

// File: rtl/vga_embarcacao.sv
// Ship renderer for the 8x8 board on 640x480 VGA. Game state is captured once
// per frame, turned into pixel borders one cycle later, and each pixel is
// coloured from the lowest-index present cell it falls strictly inside.
module vga_embarcacao #(
    parameter int       N_CELLS      = 3,
    parameter int       ORIGEM_X     = 16,
    parameter int       ORIGEM_Y     = 16,
    parameter int       PASSO_X      = 62,
    parameter int       PASSO_Y      = 57,
    parameter int       LARGURA      = 54,
    parameter int       ALTURA       = 49,
    parameter logic [2:0] COR        = 3'b110,
    parameter logic [2:0] COR_ACERTO = 3'b100,
    parameter int       BLINK_FRAMES = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    vga_embarcacao_if.slave   bus
);
    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Frame shadows
    logic [8*N_CELLS-1:0] posSh;
    logic [N_CELLS-1:0]   hitSh;
    logic                 visSh;

    // Border stage
    logic [N_CELLS-1:0][9:0] leftC, topC, leftQ, topQ;
    logic [N_CELLS-1:0]      presC, presQ, hitQ;
    logic                    visQ, sunkQ;

    // Pixel stage
    logic [N_CELLS-1:0] inCell;
    logic [2:0]         corC, rgbQ;
    logic               found;

    // Blink
    logic [CW-1:0] blinkCnt;
    logic          fasePisca;

    // Latch game state only on the frame pulse so a frame never mixes old and new state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            posSh <= '0;
            hitSh <= '0;
            visSh <= 1'b0;
        end else if (bus.inicioQuadro) begin
            posSh <= bus.posicoesEmbarcacao;
            hitSh <= bus.acertos;
            visSh <= bus.visivel;
        end
    end

    // Per-cell presence and pixel borders from the captured board coordinates
    for (genvar k = 0; k < N_CELLS; k++) begin : gCell
        logic [3:0] cx, cy;
        assign cx       = posSh[8*k +: 4];
        assign cy       = posSh[8*k+4 +: 4];
        assign presC[k] = (cx >= 4'd1) && (cx <= 4'd8) && (cy >= 4'd1) && (cy <= 4'd8);
        assign leftC[k] = 10'(ORIGEM_X) + ({6'd0, cx} - 10'd1) * 10'(PASSO_X);
        assign topC[k]  = 10'(ORIGEM_Y) + ({6'd0, cy} - 10'd1) * 10'(PASSO_Y);

        // Strict inequalities: the border pixels themselves are not part of the cell
        assign inCell[k] = (bus.linha > topQ[k]) &&
                           ({1'b0, bus.linha} < ({1'b0, topQ[k]} + 11'(ALTURA))) &&
                           (bus.coluna > leftQ[k]) &&
                           ({1'b0, bus.coluna} < ({1'b0, leftQ[k]} + 11'(LARGURA)));
    end

    // Register borders together with hits/visibility so the pixel path sees one consistent snapshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leftQ <= '0;
            topQ  <= '0;
            presQ <= '0;
            hitQ  <= '0;
            visQ  <= 1'b0;
            sunkQ <= 1'b0;
        end else begin
            leftQ <= leftC;
            topQ  <= topC;
            presQ <= presC;
            hitQ  <= hitSh;
            visQ  <= visSh;
            sunkQ <= (presC != '0) && ((hitSh & presC) == presC);
        end
    end

    // Colour from the lowest-index present cell under the pixel
    always_comb begin
        corC  = 3'b000;
        found = 1'b0;
        for (int k = 0; k < N_CELLS; k++) begin
            if (!found && presQ[k] && inCell[k]) begin
                found = 1'b1;
                if (hitQ[k])   corC = COR_ACERTO;
                else if (visQ) corC = COR;
            end
        end
        if (!bus.areaAtiva || (sunkQ && !fasePisca)) corC = 3'b000;
    end

    // One-cycle registered colour output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rgbQ <= 3'b000;
        else        rgbQ <= corC;
    end

    // Blink phase: advance once per frame while sunk, held at "on" otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blinkCnt  <= '0;
            fasePisca <= 1'b1;
        end else if (!sunkQ) begin
            blinkCnt  <= '0;
            fasePisca <= 1'b1;
        end else if (bus.inicioQuadro) begin
            if (blinkCnt == CW'(BLINK_FRAMES - 1)) begin
                blinkCnt  <= '0;
                fasePisca <= ~fasePisca;
            end else begin
                blinkCnt  <= blinkCnt + 1'b1;
            end
        end
    end

    assign bus.rgb_r    = rgbQ[2];
    assign bus.rgb_g    = rgbQ[1];
    assign bus.rgb_b    = rgbQ[0];
    assign bus.afundada = sunkQ;
endmodule

// File: tb/tb_vga_embarcacao.sv
// Directed bench for the ship renderer (3 cells, 2-frame blink half-period).
module tb_vga_embarcacao;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    vga_embarcacao_if #(.N_CELLS(3)) bus ();

    vga_embarcacao #(.N_CELLS(3), .BLINK_FRAMES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout rgb=%b%b%b", bus.rgb_r, bus.rgb_g, bus.rgb_b);
        $fatal(1, "timeout");
    end

    function automatic logic [2:0] rgb();
        return {bus.rgb_r, bus.rgb_g, bus.rgb_b};
    endfunction

    // Present a pixel and wait until its registered colour is visible
    task automatic pix(input logic [9:0] l, input logic [9:0] c, input logic a);
        @(negedge clk);
        bus.linha = l; bus.coluna = c; bus.areaAtiva = a;
        @(negedge clk);
    endtask

    // Frame pulse, then wait until the new borders are in use
    task automatic pulse();
        @(negedge clk);
        bus.inicioQuadro = 1'b1;
        @(negedge clk);
        bus.inicioQuadro = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.areaAtiva = 1'b1; bus.inicioQuadro = 1'b1;
        bus.linha = 10'd40; bus.coluna = 10'd40;
        bus.posicoesEmbarcacao = 24'h131211; bus.acertos = 3'b111; bus.visivel = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rgb() !== 3'b000) begin errors++; $display("FAIL rst_rgb got=%b exp=000", rgb()); end
        checks++; if (bus.afundada !== 1'b0) begin errors++; $display("FAIL rst_afundada got=%b exp=0", bus.afundada); end
        bus.inicioQuadro = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        pix(10'd40, 10'd40, 1'b1);
        checks++; if (rgb() !== 3'b000) begin errors++; $display("FAIL rst_nocapture got=%b exp=000", rgb()); end
        pix(10'd40, 10'd100, 1'b1);
        checks++; if (rgb() !== 3'b000) begin errors++; $display("FAIL rst_nocapture2 got=%b exp=000", rgb()); end
    endtask

    task automatic test_draw();
        bus.posicoesEmbarcacao = 24'h131211; bus.acertos = 3'b000; bus.visivel = 1'b1;
        pulse();
        pix(10'd40, 10'd40, 1'b1);
        checks++; if (rgb() !== 3'b110) begin errors++; $display("FAIL draw_c0 got=%b exp=110", rgb()); end
        pix(10'd16, 10'd40, 1'b1);
        checks++; if (rgb() !== 3'b000) begin errors++; $display("FAIL draw_topedge got=%b exp=000", rgb()); end
        pix(10'd17, 10'd17, 1'b1);
        checks++; if (rgb() !== 3'b110) begin errors++; $display("FAIL draw_corner_in got=%b exp=110", rgb()); end
        pix(10'd64, 10'd69, 1'b1);
        checks++; if (rgb() !== 3'b110) begin errors++; $display("FAIL draw_corner_far got=%b exp=110", rgb()); end
        pix(10'd65, 10'd40, 1'b1);
        checks++; if (rgb() !== 3'b000) begin errors++; $display("FAIL draw_botedge got=%b exp=000", rgb()); end
        pix(10'd40, 10'd100, 1'b1);
        checks++; if (rgb() !== 3'b110) begin errors++; $display("FAIL draw_c1 got=%b exp=110", rgb()); end
        pix(10'd40, 10'd193, 1'b1);
        checks++; if (rgb() !== 3'b110) begin errors++; $display("FAIL draw_c2 got=%b exp=110", rgb()); end
        pix(10'd40, 10'd194, 1'b1);
        checks++; if (rgb() !== 3'b000) begin errors++; $display("FAIL draw_rightedge got=%b exp=000", rgb()); end
        pix(10'd40, 10'd74, 1'b1);
        checks++; if (rgb() !== 3'b000) begin errors++; $display("FAIL draw_gap got=%b exp=000", rgb()); end
    endtask

    task automatic test_back_to_back();
        // Pixel coinciding with the capture still uses the old borders
        @(negedge clk);
        bus.posicoesEmbarcacao = 24'h232221;
        bus.linha = 10'd40; bus.coluna = 10'd40; bus.areaAtiva = 1'b1;
        bus.inicioQuadro = 1'b1;
        @(negedge clk);
        bus.inicioQuadro = 1'b0;
        checks++; if (rgb() !== 3'b110) begin errors++; $display("FAIL b2b_oldborder got=%b exp=110", rgb()); end
        @(negedge clk);
        pix(10'd40, 10'd40, 1'b1);
        checks++; if (rgb() !== 3'b000) begin errors++; $display("FAIL b2b_oldcell got=%b exp=000", rgb()); end
        pix(10'd80, 10'd40, 1'b1);
        checks++; if (rgb() !== 3'b110) begin errors++; $display("FAIL b2b_newcell got=%b exp=110", rgb()); end
        bus.posicoesEmbarcacao = 24'h131211;
        pulse();
    endtask

    task automatic test_hits();
        bus.acertos = 3'b010;
        pulse();
        pix(10'd40, 10'd100, 1'b1);
        checks++; if (rgb() !== 3'b100) begin errors++; $display("FAIL hit_c1 got=%b exp=100", rgb()); end
        pix(10'd40, 10'd40, 1'b1);
        checks++; if (rgb() !== 3'b110) begin errors++; $display("FAIL hit_c0intact got=%b exp=110", rgb()); end
        bus.visivel = 1'b0;
        pulse();
        pix(10'd40, 10'd40, 1'b1);
        checks++; if (rgb() !== 3'b000) begin errors++; $display("FAIL hidden_c0 got=%b exp=000", rgb()); end
        pix(10'd40, 10'd100, 1'b1);
        checks++; if (rgb() !== 3'b100) begin errors++; $display("FAIL hidden_hit got=%b exp=100", rgb()); end
    endtask

    task automatic test_capture_gate();
        bus.acertos = 3'b111;
        pix(10'd40, 10'd40, 1'b1);
        checks++; if (rgb() !== 3'b000) begin errors++; $display("FAIL gate_c0 got=%b exp=000", rgb()); end
        checks++; if (bus.afundada !== 1'b0) begin errors++; $display("FAIL gate_afundada got=%b exp=0", bus.afundada); end
        pulse();
        checks++; if (bus.afundada !== 1'b1) begin errors++; $display("FAIL sunk_afundada got=%b exp=1", bus.afundada); end
        pix(10'd40, 10'd40, 1'b1);
        checks++; if (rgb() !== 3'b100) begin errors++; $display("FAIL sunk_c0 got=%b exp=100", rgb()); end
    endtask

    task automatic test_blink();
        logic [2:0] exp [4] = '{3'b100, 3'b000, 3'b000, 3'b100};
        for (int i = 0; i < 4; i++) begin
            pulse();
            pix(10'd40, 10'd170, 1'b1);
            checks++;
            if (rgb() !== exp[i]) begin errors++; $display("FAIL blink_p%0d got=%b exp=%b", i + 1, rgb(), exp[i]); end
        end
        // Un-sinking resets the blink; re-sinking starts from phase on, count 0
        bus.acertos = 3'b000; bus.visivel = 1'b1;
        pulse();
        checks++; if (bus.afundada !== 1'b0) begin errors++; $display("FAIL unsink_afundada got=%b exp=0", bus.afundada); end
        pix(10'd40, 10'd40, 1'b1);
        checks++; if (rgb() !== 3'b110) begin errors++; $display("FAIL unsink_c0 got=%b exp=110", rgb()); end
        bus.acertos = 3'b111;
        pulse();
        pix(10'd40, 10'd40, 1'b1);
        checks++; if (rgb() !== 3'b100) begin errors++; $display("FAIL resink_p0 got=%b exp=100", rgb()); end
        pulse();
        pix(10'd40, 10'd40, 1'b1);
        checks++; if (rgb() !== 3'b100) begin errors++; $display("FAIL resink_p1 got=%b exp=100", rgb()); end
        pulse();
        pix(10'd40, 10'd40, 1'b1);
        checks++; if (rgb() !== 3'b000) begin errors++; $display("FAIL resink_p2 got=%b exp=000", rgb()); end
    endtask

    task automatic test_reset_blink();
        // Now sunk with blink phase off; assert reset mid-cycle
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++; if (rgb() !== 3'b000) begin errors++; $display("FAIL midrst_rgb got=%b exp=000", rgb()); end
        checks++; if (bus.afundada !== 1'b0) begin errors++; $display("FAIL midrst_afundada got=%b exp=0", bus.afundada); end
        @(negedge clk); rst_n = 1'b1;
        pix(10'd40, 10'd40, 1'b1);
        checks++; if (rgb() !== 3'b000) begin errors++; $display("FAIL midrst_invisible got=%b exp=000", rgb()); end
        pulse();
        pix(10'd40, 10'd40, 1'b1);
        checks++; if (rgb() !== 3'b100) begin errors++; $display("FAIL midrst_p0 got=%b exp=100", rgb()); end
        pulse();
        pix(10'd40, 10'd40, 1'b1);
        checks++; if (rgb() !== 3'b100) begin errors++; $display("FAIL midrst_cnt0 got=%b exp=100", rgb()); end
    endtask

    task automatic test_absent();
        bus.posicoesEmbarcacao = 24'h921011; bus.acertos = 3'b000; bus.visivel = 1'b1;
        pulse();
        checks++; if (bus.afundada !== 1'b0) begin errors++; $display("FAIL absent_unsunk got=%b exp=0", bus.afundada); end
        bus.acertos = 3'b001;
        pulse();
        checks++; if (bus.afundada !== 1'b1) begin errors++; $display("FAIL absent_sunk got=%b exp=1", bus.afundada); end
        pix(10'd40, 10'd40, 1'b1);
        checks++; if (rgb() !== 3'b100) begin errors++; $display("FAIL absent_c0 got=%b exp=100", rgb()); end
        pix(10'd40, 10'd40, 1'b0);
        checks++; if (rgb() !== 3'b000) begin errors++; $display("FAIL area_off got=%b exp=000", rgb()); end
        pix(10'd40, 10'd990, 1'b1);
        checks++; if (rgb() !== 3'b000) begin errors++; $display("FAIL absent_x0 got=%b exp=000", rgb()); end
        pix(10'd480, 10'd100, 1'b1);
        checks++; if (rgb() !== 3'b000) begin errors++; $display("FAIL absent_y9 got=%b exp=000", rgb()); end
    endtask

    initial begin
        test_reset();
        test_draw();
        test_back_to_back();
        test_hits();
        test_capture_gate();
        test_blink();
        test_reset_blink();
        test_absent();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
